bin_to_bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_digit_cell.sv | 30 +++
 rtl/bin_to_bcd_seq.sv | 136 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential
// double-dabble binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam int DIGIT_W = 4;

   function automatic logic [DIGIT_W-1:0] add3_adj(
      input logic [DIGIT_W-1:0] n
   );
      return (n >= DIGIT_W'(5)) ? n + DIGIT_W'(3) : n;
   endfunction

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the double-dabble scratch register:
// add-3 adjust, shift-in from below, carry-out upward.
module bcd_digit_cell
   import bcd_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clr,
   input  logic               en,
   input  logic               shift_in,
   output logic [DIGIT_W-1:0] q,
   output logic               carry_out
);

   logic [DIGIT_W-1:0] adj;

   assign adj       = add3_adj(q);
   assign carry_out = adj[DIGIT_W-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= {adj[DIGIT_W-2:0], shift_in};
      end
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock.
// Define LEADING_ZERO_BLANK_EN to build the blank_mask logic.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 27,
   parameter int DIGITS = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [BIN_W-1:0]          bin_in,
   output logic                      busy,
   output logic                      done,
   output logic [DIGIT_W*DIGITS-1:0] bcd_out,
   output logic                      overflow,
   output logic [DIGITS-1:0]         blank_mask
);

   localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [DIGIT_W*DIGITS-1:0] NINES = {DIGITS{4'h9}};

   state_t state, state_nxt;
   logic load, step, fin;

   logic [BIN_W-1:0]          shreg;
   logic [CNT_W-1:0]          count;
   logic                      ovf_pend;
   logic                      scr_msb;
   logic                      ovf;
   logic [DIGIT_W*DIGITS-1:0] scratch;
   logic [DIGITS:0]           carry;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      fin       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            step = 1'b1;
            if (count == '0) state_nxt = DONE;
         end
         DONE: begin
            fin       = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shreg    <= '0;
         count    <= '0;
         ovf_pend <= 1'b0;
         scr_msb  <= 1'b0;
      end else if (load) begin
         shreg    <= bin_in;
         count    <= CNT_W'(BIN_W - 1);
         ovf_pend <= 64'(bin_in) > MAX_VAL;
         scr_msb  <= 1'b0;
      end else if (step) begin
         shreg    <= shreg << 1;
         count    <= count - CNT_W'(1);
         scr_msb  <= carry[DIGITS];
      end
   end

   assign carry[0] = shreg[BIN_W-1];

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_cell u_cell (
         .clk       (clk),
         .reset_n   (reset_n),
         .clr       (load),
         .en        (step),
         .shift_in  (carry[g]),
         .q         (scratch[g*DIGIT_W +: DIGIT_W]),
         .carry_out (carry[g+1])
      );
   end

   // a carry out of the top digit can only come from an out-of-range operand
   assign ovf = ovf_pend | scr_msb;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done     <= 1'b0;
         bcd_out  <= '0;
         overflow <= 1'b0;
      end else begin
         done <= fin;
         if (fin) begin
            bcd_out  <= ovf ? NINES : scratch;
            overflow <= ovf;
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] blank_nxt;
   logic              all_zero;

   always_comb begin
      blank_nxt = '0;
      all_zero  = 1'b1;
      for (int i = DIGITS-1; i >= 1; i--) begin
         all_zero     = all_zero & (scratch[i*DIGIT_W +: DIGIT_W] == '0);
         blank_nxt[i] = all_zero;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  blank_mask <= '0;
      else if (fin)  blank_mask <= ovf ? '0 : blank_nxt;
   end
`else
   assign blank_mask = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomised bench for bin_to_bcd_seq with an
// arithmetic reference model and literal spot checks.
module tb_bin_to_bcd_seq;

   localparam int BIN_W  = 27;
   localparam int DIGITS = 8;
   localparam longint unsigned MAX_VAL = 64'd100000000 - 64'd1;

   logic                clk;
   logic                reset_n;
   logic                start;
   logic [BIN_W-1:0]    bin_in;
   logic                busy;
   logic                done;
   logic [4*DIGITS-1:0] bcd_out;
   logic                overflow;
   logic [DIGITS-1:0]   blank_mask;

   int total = 0;
   int bad   = 0;

   bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .bin_in     (bin_in),
      .busy       (busy),
      .done       (done),
      .bcd_out    (bcd_out),
      .overflow   (overflow),
      .blank_mask (blank_mask)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] to_bcd(input longint unsigned v);
      logic [31:0] r;
      longint unsigned x;
      r = '0;
      x = v;
      if (v > MAX_VAL) return 32'h99999999;
      for (int i = 0; i < DIGITS; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [7:0] to_blank(input longint unsigned v);
      logic [7:0] r;
      longint unsigned p;
      r = '0;
      p = 10;
      for (int i = 1; i < DIGITS; i++) begin
         if (v <= MAX_VAL && v < p) r[i] = 1'b1;
         p = p * 10;
      end
`ifndef LEADING_ZERO_BLANK_EN
      r = '0;
`endif
      return r;
   endfunction

   // reference model: edges left until the result appears
   int unsigned      m_cnt;
   logic [BIN_W-1:0] m_val;
   logic             m_done;
   logic [31:0]      m_bcd;
   logic             m_ovf;
   logic [7:0]       m_blank;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_cnt   <= 0;
         m_val   <= '0;
         m_done  <= 1'b0;
         m_bcd   <= '0;
         m_ovf   <= 1'b0;
         m_blank <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_cnt == 0) begin
            if (start) begin
               m_val <= bin_in;
               m_cnt <= BIN_W + 1;
            end
         end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_done  <= 1'b1;
               m_bcd   <= to_bcd(64'(m_val));
               m_ovf   <= 64'(m_val) > MAX_VAL;
               m_blank <= to_blank(64'(m_val));
            end
         end
      end
   end

   task automatic check(input string name, input longint unsigned act,
                        input longint unsigned exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("busy",       64'(busy),       64'(m_cnt != 0));
      check("done",       64'(done),       64'(m_done));
      check("bcd_out",    64'(bcd_out),    64'(m_bcd));
      check("overflow",   64'(overflow),   64'(m_ovf));
      check("blank_mask", 64'(blank_mask), 64'(m_blank));
   end

   // called at a negedge; returns at the negedge where done is seen
   task automatic run(input logic [BIN_W-1:0] v, input bit noise,
                      output int lat, output int busy_n);
      bit seen;
      seen   = 1'b0;
      lat    = 0;
      busy_n = 0;
      start  = 1'b1;
      bin_in = v;
      for (int n = 1; n <= 60 && !seen; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (noise) begin
            start  = 1'($urandom_range(0, 1));
            bin_in = BIN_W'($urandom);
         end
         if (busy) busy_n++;
         if (done) begin
            seen = 1'b1;
            lat  = n - 1;
         end
      end
      start = 1'b0;
      if (!seen) check("done_timeout", 0, 1);
   endtask

   int lat, bn, dn;
   logic [BIN_W-1:0] r;
   logic [7:0] exp_b0, exp_b305;

   initial begin
`ifdef LEADING_ZERO_BLANK_EN
      exp_b0   = 8'hFE;
      exp_b305 = 8'hF8;
`else
      exp_b0   = 8'h00;
      exp_b305 = 8'h00;
`endif
      reset_n = 1'b1;
      start   = 1'b0;
      bin_in  = '0;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 0);
      check("rst_done", 64'(done), 0);
      check("rst_bcd",  64'(bcd_out), 0);
      check("rst_ovf",  64'(overflow), 0);
      check("rst_blank", 64'(blank_mask), 0);
      reset_n = 1'b1;
      @(negedge clk);

      run(27'd12345678, 1'b0, lat, bn);
      check("lat_12345678", 64'(lat), 28);
      check("busy_cycles", 64'(bn), 28);
      check("bcd_12345678", 64'(bcd_out), 64'h12345678);
      check("ovf_12345678", 64'(overflow), 0);

      run(27'd99999999, 1'b0, lat, bn);
      check("bcd_max", 64'(bcd_out), 64'h99999999);
      check("ovf_max", 64'(overflow), 0);
      run(27'd100000000, 1'b0, lat, bn);
      check("b2b_spacing", 64'(lat), 28);
      check("bcd_over", 64'(bcd_out), 64'h99999999);
      check("ovf_over", 64'(overflow), 1);
      check("blank_over", 64'(blank_mask), 0);

      run(27'd0, 1'b0, lat, bn);
      check("bcd_zero", 64'(bcd_out), 0);
      check("blank_zero", 64'(blank_mask), 64'(exp_b0));
      run(27'd305, 1'b0, lat, bn);
      check("bcd_305", 64'(bcd_out), 64'h305);
      check("blank_305", 64'(blank_mask), 64'(exp_b305));

      // start held high: captures only at edges 0, 29, 58, 87
      dn = 0;
      for (int n = 0; n < 150; n++) begin
         start  = (n < 90);
         bin_in = BIN_W'($urandom);
         @(negedge clk);
         if (done) dn++;
      end
      start = 1'b0;
      check("held_start_dones", 64'(dn), 4);

      for (int k = 0; k < 20; k++) begin
         r = (k % 3 == 0) ? BIN_W'($urandom)
                          : BIN_W'($urandom_range(0, 99999999));
         run(r, 1'b1, lat, bn);
         check("rand_lat", 64'(lat), 28);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      run(27'd99999999, 1'b0, lat, bn);
      start  = 1'b1;
      bin_in = 27'd4242;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_bcd",  64'(bcd_out), 0);
      check("mid_rst_busy", 64'(busy), 0);
      check("mid_rst_done", 64'(done), 0);
      check("mid_rst_ovf",  64'(overflow), 0);
      dn = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) dn++;
      end
      reset_n = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (done) dn++;
      end
      check("no_done_after_rst", 64'(dn), 0);

      run(27'd7, 1'b0, lat, bn);
      check("lat_7", 64'(lat), 28);
      check("bcd_7", 64'(bcd_out), 64'h7);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
